// File: rtl/rf_writeback_unit_pkg.sv
// Shared widths, the write-back record and the register-zero constant for the
// register-file write-back unit.
package rf_writeback_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_rec_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Synchronous FIFO for load responses waiting for the register-file write port.
// No fall-through: an entry pushed into an empty FIFO is visible one edge later.
module wb_load_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/rf_writeback_unit.sv
// Register-file write port owner: arbitrates ALU results over queued load
// responses and tracks in-flight loads for decode-stage hazard stalls.
module rf_writeback_unit #(
  parameter int unsigned XLEN     = rf_writeback_unit_pkg::XLEN,
  parameter int unsigned AW       = rf_writeback_unit_pkg::AW,
  parameter int unsigned LQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alu_valid,
  input  logic [AW-1:0]               alu_rd,
  input  logic [XLEN-1:0]             alu_data,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [AW-1:0]               ld_rd,
  input  logic [XLEN-1:0]             ld_data,
  input  logic                        iss_valid,
  input  logic                        iss_is_load,
  input  logic [AW-1:0]               iss_rd,
  input  logic [AW-1:0]               q_rs1,
  input  logic [AW-1:0]               q_rs2,
  output logic                        busy_rs1,
  output logic                        busy_rs2,
  output logic                        rf_we,
  output logic [AW-1:0]               rf_a3,
  output logic [XLEN-1:0]             rf_wd,
  output logic [$clog2(LQ_DEPTH):0]   lq_count
);

  import rf_writeback_unit_pkg::*;

  localparam int unsigned NREG = 1 << AW;

  wb_rec_t          push_rec, head;
  logic             lq_full, lq_empty, pop;
  logic [NREG-1:0]  pend_q, pend_d;
  logic             rf_we_q;
  logic [AW-1:0]    rf_a3_q;
  logic [XLEN-1:0]  rf_wd_q;

  assign push_rec = '{rd: ld_rd, data: ld_data};
  assign ld_ready = !lq_full;
  // ALU results cannot be back-pressured, so loads only drain on ALU-idle cycles.
  assign pop      = !alu_valid && !lq_empty;

  wb_load_fifo #(
    .DEPTH (LQ_DEPTH),
    .WIDTH ($bits(wb_rec_t))
  ) u_lq (
    .clk   (clk),
    .rst   (rst),
    .push  (ld_valid && ld_ready),
    .pop   (pop),
    .wdata (push_rec),
    .rdata (head),
    .full  (lq_full),
    .empty (lq_empty),
    .count (lq_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q <= 1'b0;
      rf_a3_q <= '0;
      rf_wd_q <= '0;
    end else if (alu_valid) begin
      rf_we_q <= (alu_rd != REG_ZERO);
      rf_a3_q <= alu_rd;
      rf_wd_q <= alu_data;
    end else if (pop) begin
      rf_we_q <= (head.rd != REG_ZERO);
      rf_a3_q <= head.rd;
      rf_wd_q <= head.data;
    end else begin
      rf_we_q <= 1'b0;
    end
  end

  assign rf_we = rf_we_q;
  assign rf_a3 = rf_a3_q;
  assign rf_wd = rf_wd_q;

  // Clear before set so a re-issued load to the popping register stays pending.
  always_comb begin
    pend_d = pend_q;
    if (pop) pend_d[head.rd] = 1'b0;
    if (iss_valid && iss_is_load && (iss_rd != REG_ZERO)) pend_d[iss_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  assign busy_rs1 = pend_q[q_rs1] && (q_rs1 != REG_ZERO);
  assign busy_rs2 = pend_q[q_rs2] && (q_rs2 != REG_ZERO);

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Directed bench for rf_writeback_unit: a queue-based reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_rf_writeback_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 0, ld_valid = 0, iss_valid = 0, iss_is_load = 0;
  logic [4:0]  alu_rd = 0, ld_rd = 0, iss_rd = 0, q_rs1 = 0, q_rs2 = 0;
  logic [31:0] alu_data = 0, ld_data = 0;
  logic        ld_ready, busy_rs1, busy_rs2, rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [2:0]  lq_count;

  int vectors = 0;
  int errors  = 0;

  rf_writeback_unit #(.LQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .iss_valid(iss_valid), .iss_is_load(iss_is_load), .iss_rd(iss_rd),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .lq_count(lq_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending writes and a set of pending load targets.
  typedef struct { logic [4:0] rd; logic [31:0] data; } mrec_t;
  mrec_t       lq[$];
  bit  [31:0]  m_pend = '0;
  logic        m_we = 0;
  logic [4:0]  m_a3 = 0;
  logic [31:0] m_wd = 0;

  always @(posedge clk or posedge rst) begin
    int    sz;
    mrec_t r;
    if (rst) begin
      lq.delete();
      m_pend = '0;
      m_we = 0; m_a3 = 0; m_wd = 0;
    end else begin
      sz = lq.size();
      if (alu_valid) begin
        m_we = (alu_rd != 0); m_a3 = alu_rd; m_wd = alu_data;
      end else if (sz > 0) begin
        r = lq.pop_front();
        m_we = (r.rd != 0); m_a3 = r.rd; m_wd = r.data;
        m_pend[r.rd] = 1'b0;
      end else begin
        m_we = 0;
      end
      if (ld_valid && sz != DEPTH) lq.push_back('{rd: ld_rd, data: ld_data});
      if (iss_valid && iss_is_load && iss_rd != 0) m_pend[iss_rd] = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("m_rf_we", 32'(rf_we), 32'(m_we));
    chk("m_rf_a3", 32'(rf_a3), 32'(m_a3));
    chk("m_rf_wd", rf_wd, m_wd);
    chk("m_ld_ready", 32'(ld_ready), 32'(lq.size() != DEPTH));
    chk("m_lq_count", 32'(lq_count), 32'(lq.size()));
    chk("m_busy_rs1", 32'(busy_rs1), 32'(m_pend[q_rs1] && q_rs1 != 0));
    chk("m_busy_rs2", 32'(busy_rs2), 32'(m_pend[q_rs2] && q_rs2 != 0));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset release, idle.
    tick(); tick();
    rst = 0;
    tick();
    chk("rst_we", 32'(rf_we), 0);
    chk("rst_a3", 32'(rf_a3), 0);
    chk("rst_wd", rf_wd, 0);
    chk("rst_ready", 32'(ld_ready), 1);
    chk("rst_count", 32'(lq_count), 0);
    chk("rst_busy", 32'({busy_rs1, busy_rs2}), 0);

    // ALU write, then ALU write to x0.
    alu_valid = 1; alu_rd = 5; alu_data = 32'hAA;
    tick();
    chk("alu_we", 32'(rf_we), 1);
    chk("alu_a3", 32'(rf_a3), 5);
    chk("alu_wd", rf_wd, 32'hAA);
    alu_rd = 0; alu_data = 32'h55;
    tick();
    chk("alu_x0_we", 32'(rf_we), 0);
    alu_valid = 0;
    tick();

    // Load to x7 delayed behind three ALU writes.
    iss_valid = 1; iss_is_load = 1; iss_rd = 7; q_rs1 = 7;
    tick();
    iss_valid = 0; iss_is_load = 0;
    chk("ld7_busy_issue", 32'(busy_rs1), 1);
    ld_valid = 1; ld_rd = 7; ld_data = 32'h1234;
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
    tick();
    ld_valid = 0;
    chk("ld7_busy_a1", 32'(busy_rs1), 1);
    chk("ld7_count", 32'(lq_count), 1);
    tick();
    chk("ld7_busy_a2", 32'(busy_rs1), 1);
    tick();
    chk("ld7_busy_a3", 32'(busy_rs1), 1);
    chk("ld7_a3_alu", 32'(rf_a3), 3);
    alu_valid = 0;
    tick();
    chk("ld7_we", 32'(rf_we), 1);
    chk("ld7_a3", 32'(rf_a3), 7);
    chk("ld7_wd", rf_wd, 32'h1234);
    chk("ld7_busy_pop", 32'(busy_rs1), 0);

    // Fill the FIFO behind a stream of ALU writes; the fifth offer is refused.
    alu_valid = 1; alu_rd = 3; alu_data = 32'h77;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1; ld_rd = 5'(10 + i); ld_data = 32'(256 + i);
      tick();
    end
    chk("full_count", 32'(lq_count), 4);
    chk("full_ready", 32'(ld_ready), 0);
    ld_rd = 14; ld_data = 32'h999;
    tick();
    chk("full_count5", 32'(lq_count), 4);
    chk("full_a3_alu", 32'(rf_a3), 3);
    ld_valid = 0; alu_valid = 0;
    tick();
    chk("drain0_a3", 32'(rf_a3), 10);
    chk("drain0_wd", rf_wd, 32'd256);
    chk("drain0_ready", 32'(ld_ready), 1);
    chk("drain0_count", 32'(lq_count), 3);
    tick(); tick();
    chk("drain2_a3", 32'(rf_a3), 12);
    tick();
    chk("drain3_wd", rf_wd, 32'd259);
    chk("drain3_count", 32'(lq_count), 0);
    tick();
    chk("drain_idle_we", 32'(rf_we), 0);
    chk("drain_idle_a3", 32'(rf_a3), 13);

    // Re-issue a load to x9 on the edge its previous load pops: set wins.
    iss_valid = 1; iss_is_load = 1; iss_rd = 9; q_rs2 = 9;
    tick();
    iss_valid = 0;
    ld_valid = 1; ld_rd = 9; ld_data = 32'h9009; alu_valid = 1; alu_rd = 4;
    tick();
    ld_valid = 0; alu_valid = 0;
    iss_valid = 1;
    tick();
    iss_valid = 0; iss_is_load = 0;
    chk("x9_a3", 32'(rf_a3), 9);
    chk("x9_wd", rf_wd, 32'h9009);
    chk("x9_busy", 32'(busy_rs2), 1);
    tick();
    chk("x9_busy_hold", 32'(busy_rs2), 1);

    // Mid-operation asynchronous reset with three loads queued.
    q_rs1 = 20; q_rs2 = 21;
    alu_valid = 1; alu_rd = 6; alu_data = 32'hCAFE;
    for (int i = 0; i < 3; i++) begin
      iss_valid = 1; iss_is_load = 1; iss_rd = 5'(20 + i);
      ld_valid = 1; ld_rd = 5'(20 + i); ld_data = 32'(4096 + i);
      tick();
    end
    iss_valid = 0; iss_is_load = 0; ld_valid = 0;
    chk("pre_rst_count", 32'(lq_count), 3);
    chk("pre_rst_busy", 32'({busy_rs1, busy_rs2}), 3);
    rst = 1;
    #1;
    chk("arst_we", 32'(rf_we), 0);
    chk("arst_a3", 32'(rf_a3), 0);
    chk("arst_wd", rf_wd, 0);
    chk("arst_count", 32'(lq_count), 0);
    chk("arst_ready", 32'(ld_ready), 1);
    chk("arst_busy", 32'({busy_rs1, busy_rs2}), 0);
    alu_valid = 0;
    q_rs2 = 9;
    tick();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_we", 32'(rf_we), 0);
    end
    chk("post_rst_busy9", 32'(busy_rs2), 0);
    chk("post_rst_count", 32'(lq_count), 0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/rf_writeback_unit.md
Name: rf_writeback_unit

Overview:
- Write-side front end of the integer register file. It owns the single write port: it drives the file's write-address, write-enable and write-data inputs, which the file samples on the falling clock edge.
- It merges single-cycle ALU results with variable-latency load responses, using a valid/ready handshake and a small FIFO for loads.
- It keeps a pending-load scoreboard, so the decode stage can stall on rs1/rs2 read-after-write hazards against loads still in flight.

Parameters:
- XLEN, 32, data width of register values.
- AW, 5, register address width (32 registers).
- LQ_DEPTH, 4, load-response FIFO depth; must be a power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- alu_valid  input  1  ALU result present this cycle; always accepted.
- alu_rd  input  AW  ALU destination register.
- alu_data  input  XLEN  ALU result.
- ld_valid  input  1  load response offered.
- ld_ready  output  1  load FIFO can accept; equals (count != LQ_DEPTH).
- ld_rd  input  AW  load destination register.
- ld_data  input  XLEN  load data.
- iss_valid  input  1  instruction issued this cycle.
- iss_is_load  input  1  the issued instruction is a load.
- iss_rd  input  AW  destination of the issued instruction.
- q_rs1  input  AW  decode-stage source-register query 1.
- q_rs2  input  AW  decode-stage source-register query 2.
- busy_rs1  output  1  pending load targets q_rs1 (combinational).
- busy_rs2  output  1  pending load targets q_rs2 (combinational).
- rf_we  output  1  register-file write enable (registered).
- rf_a3  output  AW  register-file write address (registered).
- rf_wd  output  XLEN  register-file write data (registered).
- lq_count  output  clog2(LQ_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, highest priority, also mid-operation):
  - rf_we=0, rf_a3=0, rf_wd=0.
  - FIFO emptied (lq_count=0, ld_ready=1); queued loads are discarded.
  - Scoreboard pend[31:0] cleared to 0.
- Load enqueue: occurs at a rising edge when ld_valid && ld_ready. Data and rd are held in the FIFO at the tail; pointers wrap modulo LQ_DEPTH.
- Write-port arbitration, evaluated each rising edge; the output register loads the winner:
  - Priority 1: alu_valid. Load rf_a3=alu_rd, rf_wd=alu_data, rf_we=(alu_rd!=0).
  - Priority 2: FIFO not empty. Pop the head; load rf_a3=head.rd, rf_wd=head.data, rf_we=(head.rd!=0).
  - Otherwise: rf_we=0; rf_a3 and rf_wd hold their previous values.
- x0 rule: a winner with rd=0 is consumed (popped, or treated as the accepted ALU result), but rf_we stays 0.
- Latency:
  - ALU result presented before edge N drives rf_we high for cycle N..N+1. The file commits it at that cycle's falling edge.
  - Load accepted at edge N pops at edge N+1 at the earliest, so rf_we is high in cycle N+1..N+2. Each cycle with an ALU write delays the pop by one more cycle.
- Simultaneous push and pop in the same edge: count is unchanged. A push into a full FIFO cannot happen because ld_ready=0.
- Push into an empty FIFO: the entry is not popped in the same edge. There is no fall-through path.
- Scoreboard:
  - Set: at an edge, iss_valid && iss_is_load && iss_rd!=0 sets pend[iss_rd].
  - Clear: pend[head.rd] clears on the edge that pops that load.
  - Set and clear of the same register in the same edge: set wins.
  - busy_rsN = pend[q_rsN] && (q_rsN != 0).
  - pend[0] is never set.
- Ordering contract: the pipeline stalls on busy, so an ALU write never targets a register with a pending load. The block does not reorder to enforce this.
- lq_count updates at the rising edge.

Decomposition:
- Shared package:
  - XLEN and AW constants.
  - A typedef for the write-back record {rd[AW-1:0], data[XLEN-1:0]}.
  - A constant for register zero (REG_ZERO = 0).
- Sub-module wb_load_fifo: synchronous FIFO with parameters DEPTH and WIDTH, and ports push, pop, full, empty, count.
- rf_writeback_unit contains the arbiter, the output register and the scoreboard.

Test Plan:
- Reset release, idle -> rf_we=0, rf_a3=0, rf_wd=0, ld_ready=1, lq_count=0, busy_rs1=busy_rs2=0.
- alu_valid=1, rd=5, data=0x0000_00AA for one cycle -> the next cycle shows rf_we=1, rf_a3=5, rf_wd=0xAA. With rd=0 instead, the next cycle shows rf_we=0.
- Issue load rd=7; one cycle later respond with rd=7, data=0x1234 while alu_valid is held 1 for 3 cycles (ALU rd=3) ->
  - busy for q_rs1=7 stays high throughout.
  - The load write (rf_a3=7, rf_wd=0x1234) appears in the cycle after ALU activity ends.
  - busy drops on the same edge the load pops.
- Hold alu_valid=1 and offer 5 back-to-back loads with LQ_DEPTH=4 -> ld_ready=0 after 4 accepts, lq_count=4, 5th not taken. Drop alu_valid -> loads write in FIFO order, one per cycle, and ld_ready returns after the first pop.
- Issue a load to rd=9 in the same cycle the queued load to rd=9 pops -> pend[9] remains set and busy_rs2 (q_rs2=9) stays 1.
- Assert rst asynchronously with 3 loads queued and pend bits set -> outputs zero immediately, lq_count=0, all busy low. No queued write appears after rst deasserts.
